// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one decoder-style full-adder cell, LSB first, start/busy/done handshake.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds the sub input port).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: start is sampled only in IDLE; busy is high for exactly WIDTH
  // cycles in RUN; done pulses for one cycle in DONE, when sum/cout are fresh.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, work;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [7:0]       dec;
  logic             fa_s, fa_c;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and inject a carry of 1.
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_load = b;
    c_load = cin;
  end
`endif

  // Full-adder cell: one-hot decode of {a,b,c}; sum on 1/2/4/7, carry on 3/5/6/7.
  always_comb begin
    dec  = 8'd1 << {a_sr[0], b_sr[0], carry};
    fa_s = |(dec & 8'b1001_0110);
    fa_c = |(dec & 8'b1110_1000);
  end

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          work  <= {fa_s, work[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          // Publish on the final bit so results are visible as DONE begins.
          if (last) begin
            sum  <= {fa_s, work[WIDTH-1:1]};
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random bench for serial_adder_ctrl (WIDTH=8 plus an exhaustive WIDTH=2 instance).
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
  logic         start2, cin2, busy2, done2, cout2;
  logic [1:0]   a2, b2, sum2;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub, sub2;
`endif

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} = a + b + cin, or a + ~b + 1 when subtracting.
  function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                       input logic tc, input logic tsub);
    logic [W-1:0] nb;
    nb = ~tb_v;
    if (tsub) return {1'b0, ta} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
  endfunction

  task automatic run8(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic tsub);
    logic [W:0] exp;
    int bc;
    int waitc;
    exp = model(ta, tb_v, tc, tsub);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = tsub;
`endif
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    bc = 0;
    waitc = 0;
    while (!done && waitc < W + 4) begin
      if (busy) bc++;
      if (waitc == 3) chk("sum_held_in_run", sum, held_sum);
      @(negedge clk);
      waitc++;
    end
    chk("done_seen", done, 1);
    chk("busy_cycles", bc, W);
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
    held_sum = exp[W-1:0];
    held_cout = exp[W];
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic run2(input logic [1:0] ta, input logic [1:0] tb_v, input logic tc);
    logic [2:0] exp;
    int waitc;
    exp = {1'b0, ta} + {1'b0, tb_v} + {2'b0, tc};
    @(negedge clk);
    a2 = ta; b2 = tb_v; cin2 = tc; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    waitc = 0;
    while (!done2 && waitc < 8) begin
      @(negedge clk);
      waitc++;
    end
    chk("w2_done_seen", done2, 1);
    chk("w2_result", {cout2, sum2}, exp);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0; sub2 = 1'b0;
`endif
    held_sum = '0; held_cout = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_w2", {busy2, done2, cout2, sum2}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run8(8'h5A, 8'h33, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 1'b0);

    // Start pulse on RUN cycle 3 must be ignored.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("busy_start_one_done", dcnt, 1);
    chk("busy_start_sum", sum, 8'h8D);
    chk("busy_start_cout", cout, 0);
    chk("busy_start_no_restart", busy, 0);
    held_sum = 8'h8D; held_cout = 1'b0;

    // Reset on RUN cycle 4 aborts the operation.
    a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);
    held_sum = '0; held_cout = 1'b0;
    run8(8'h0F, 8'h01, 1'b0, 1'b0);
    chk("fresh_after_reset", sum, 8'h10);

    for (int i = 0; i < 20; i++)
      run8(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    for (int i = 0; i < 32; i++)
      run2(i[4:3], i[2:1], i[0]);

`ifdef SERIAL_ADDER_SUB_EN
    run8(8'h10, 8'h01, 1'b0, 1'b1);
    chk("sub_10_01", {cout, sum}, 9'h10F);
    run8(8'h00, 8'h01, 1'b1, 1'b1);
    chk("sub_borrow", {cout, sum}, 9'h0FF);
    run8(8'h10, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      run8(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
